// File: rtl/spi_host_master.sv
// spi_host_master: host-side SPI master for the spiMemory peripheral.
// Turns a one-cycle parallel request (read/write, 7-bit address, 8-bit data)
// into one chip-select-framed, MSB-first SPI transaction:
//   {addr[6:0], rw}, then RD_DUMMY/WR_DUMMY idle sclk periods, then the data byte.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start, rw, addr, wdata request strobe and payload (latched at accept)
//   busy, done, rdata      status, end-of-transaction pulse, last read byte
//   sclk_pin, cs_pin,      SPI clock (idle low), chip select (active low),
//   mosi_pin, miso_pin     serial data out / in
//   verify_err             only with SPI_HOST_READBACK_EN: write readback mismatch
// Optional feature macro: SPI_HOST_READBACK_EN (each write is re-read and compared).
module spi_host_master #(
    parameter int unsigned CLKDIV   = 50,
    parameter int unsigned RD_DUMMY = 3,
    parameter int unsigned WR_DUMMY = 0,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
`ifdef SPI_HOST_READBACK_EN
    ,
    output logic       verify_err
`endif
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned PER_W = 5;
    localparam int unsigned GAP_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           r_state, w_state;
    logic [DIV_W-1:0] r_div, w_div;
    logic [PER_W-1:0] r_per, w_per;
    logic [GAP_W-1:0] r_gap, w_gap;
    logic             r_rw, w_rw;
    logic [15:0]      r_tx, w_tx;
    logic [7:0]       r_rx, w_rx;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic [7:0]       r_rdata, w_rdata;
    logic             r_sclk, w_sclk;
    logic             r_cs, w_cs;
    logic             r_mosi, w_mosi;
`ifdef SPI_HOST_READBACK_EN
    logic [6:0]       r_addr, w_addr;
    logic [7:0]       r_wdata, w_wdata;
    logic             r_verr, w_verr;
`endif

    logic             w_tick;
    logic [PER_W-1:0] w_dummy;
    logic [PER_W-1:0] w_last;
    logic [PER_W-1:0] w_np;
    logic             w_np_dummy;
    logic             w_rd_phase;

    // Half-period strobe and frame geometry for the frame in flight
    assign w_tick     = (r_div == DIV_W'(CLKDIV - 1));
    assign w_dummy    = r_rw ? PER_W'(RD_DUMMY) : PER_W'(WR_DUMMY);
    assign w_last     = PER_W'(15) + w_dummy;
    assign w_np       = r_per + PER_W'(1);
    assign w_np_dummy = (w_np >= PER_W'(8)) && (w_np < PER_W'(8) + w_dummy);
    // r_per already holds the index of the period whose rising edge is next
    assign w_rd_phase = r_rw && (r_per >= PER_W'(8) + w_dummy);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_per   <= '0;
            r_gap   <= '0;
            r_rw    <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
`ifdef SPI_HOST_READBACK_EN
            r_addr  <= '0;
            r_wdata <= '0;
            r_verr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_per   <= w_per;
            r_gap   <= w_gap;
            r_rw    <= w_rw;
            r_tx    <= w_tx;
            r_rx    <= w_rx;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_rdata <= w_rdata;
            r_sclk  <= w_sclk;
            r_cs    <= w_cs;
            r_mosi  <= w_mosi;
`ifdef SPI_HOST_READBACK_EN
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_verr  <= w_verr;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state = r_state;
        w_div   = (r_state == IDLE || w_tick) ? '0 : r_div + DIV_W'(1);
        w_per   = r_per;
        w_gap   = r_gap;
        w_rw    = r_rw;
        w_tx    = r_tx;
        w_rx    = r_rx;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_rdata = r_rdata;
        w_sclk  = r_sclk;
        w_cs    = r_cs;
        w_mosi  = r_mosi;
`ifdef SPI_HOST_READBACK_EN
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_verr  = r_verr;
`endif
        case (r_state)
            IDLE: begin
                // r_done blocks a start arriving in the done cycle
                if (start && !r_done) begin
                    w_rw    = rw;
                    w_tx    = {addr, rw, (rw ? 8'h00 : wdata)};
                    w_busy  = 1'b1;
                    w_cs    = 1'b0;
                    w_mosi  = addr[6];
                    w_state = SETUP;
`ifdef SPI_HOST_READBACK_EN
                    w_addr  = addr;
                    w_wdata = wdata;
                    w_verr  = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_sclk  = 1'b1;
                    w_per   = '0;
                    w_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_sclk) begin
                        w_sclk = 1'b0;
                        if (r_per == w_last) begin
                            w_state = HOLD;
                        end else begin
                            w_per = w_np;
                            // Dummy periods send zero and leave the shifter parked
                            if (w_np_dummy) begin
                                w_mosi = 1'b0;
                            end else begin
                                w_mosi = r_tx[14];
                                w_tx   = {r_tx[14:0], 1'b0};
                            end
                        end
                    end else begin
                        w_sclk = 1'b1;
                        if (w_rd_phase) begin
                            w_rx = {r_rx[6:0], miso_pin};
                        end
                    end
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_cs    = 1'b1;
                    w_gap   = '0;
                    w_state = GAP;
                end
            end
            GAP: begin
                if (w_tick) begin
                    if (r_gap == GAP_W'(CS_GAP - 1)) begin
`ifdef SPI_HOST_READBACK_EN
                        if (!r_rw) begin
                            // Chain a read of the same address; busy stays high
                            w_rw    = 1'b1;
                            w_tx    = {r_addr, 1'b1, 8'h00};
                            w_cs    = 1'b0;
                            w_mosi  = r_addr[6];
                            w_state = SETUP;
                        end else begin
                            w_done  = 1'b1;
                            w_busy  = 1'b0;
                            w_rdata = r_rx;
                            w_verr  = (r_rx != r_wdata) && (r_wdata != 8'h00 || r_rx != 8'h00) ? (r_rx != r_wdata) : 1'b0;
                            w_state = IDLE;
                        end
`else
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        if (r_rw) begin
                            w_rdata = r_rx;
                        end
                        w_state = IDLE;
`endif
                    end else begin
                        w_gap = r_gap + GAP_W'(1);
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign sclk_pin = r_sclk;
    assign cs_pin   = r_cs;
    assign mosi_pin = r_mosi;
`ifdef SPI_HOST_READBACK_EN
    assign verify_err = r_verr;
`endif

endmodule
